// File: rtl/regfile_arb_pkg.sv
// Shared defaults and arbiter state encoding for the register-file arbiter.
// LAST_B is the reset state, so requester A wins the first contention.
package regfile_arb_pkg;

   localparam int NREGS_DEF = 10;
   localparam int DW_DEF    = 32;
   localparam int AW_DEF    = 4;

   typedef enum logic {
      LAST_A = 1'b0,
      LAST_B = 1'b1
   } arb_state_t;

endpackage

// File: rtl/regfile_arbiter_bank.sv
// Register storage with one registered read port and one write port.
// A same-edge write and read of one index returns the pre-write value.
module reg_file_bank
   import regfile_arb_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int DW    = DW_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          rvalid,
   output logic [DW-1:0] rdata,
   output logic          rerr
);

   logic [DW-1:0] mem [NREGS];
   logic          rd_ok;
   logic          wr_ok;

   assign rd_ok = 32'(rd_addr) < NREGS;
   assign wr_ok = 32'(wr_addr) < NREGS;

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rerr   <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         rvalid <= rd_en;
         rerr   <= rd_en && !rd_ok;
         rdata  <= (rd_en && rd_ok) ? mem[rd_addr] : '0;
         // Out-of-range writes are dropped entirely.
         if (wr_en && wr_ok) begin
            mem[wr_addr] <= wr_data;
         end
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a shared register-file read port.
// Grants are combinational; read data returns one cycle later to the granted owner.
module regfile_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int DW    = DW_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic [AW-1:0] a_addr,
   output logic          a_gnt,
   output logic          a_stall,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic [AW-1:0] b_addr,
   output logic          b_gnt,
   output logic          b_stall,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          rerr,
   output arb_state_t    state
);

   arb_state_t    state_q;
   arb_state_t    state_d;
   logic          owner_b;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          bank_rvalid;
   logic [DW-1:0] bank_rdata;
   logic          bank_rerr;
   logic          resp_on;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LAST_B;
         owner_b <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_b <= b_gnt;
      end
   end

   // Contention goes to whoever was not granted last; a lone requester always wins.
   always_comb begin
      a_gnt   = 1'b0;
      b_gnt   = 1'b0;
      state_d = state_q;
      if (!rst) begin
         a_gnt = a_req && (!b_req || state_q == LAST_B);
         b_gnt = b_req && (!a_req || state_q == LAST_A);
      end
      if (a_gnt) begin
         state_d = LAST_A;
      end else if (b_gnt) begin
         state_d = LAST_B;
      end
   end

   assign a_stall = !rst && a_req && !a_gnt;
   assign b_stall = !rst && b_req && !b_gnt;
   assign rd_en   = a_gnt || b_gnt;
   assign rd_addr = a_gnt ? a_addr : b_addr;
   assign state   = state_q;

   reg_file_bank #(
      .NREGS (NREGS),
      .DW    (DW),
      .AW    (AW)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rvalid  (bank_rvalid),
      .rdata   (bank_rdata),
      .rerr    (bank_rerr)
   );

   // Reset in the cycle after a grant swallows that grant's response.
   assign resp_on  = bank_rvalid && !rst;
   assign a_rvalid = resp_on && !owner_b;
   assign b_rvalid = resp_on && owner_b;
   assign a_rdata  = a_rvalid ? bank_rdata : '0;
   assign b_rdata  = b_rvalid ? bank_rdata : '0;
   assign rerr     = bank_rerr && !rst;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: driver checks grants, monitor checks responses.
module tb_regfile_arbiter;
   import regfile_arb_pkg::*;

   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_req = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic          a_gnt, a_stall, a_rvalid;
   logic [DW-1:0] a_rdata;
   logic          b_req = 1'b0;
   logic [AW-1:0] b_addr = '0;
   logic          b_gnt, b_stall, b_rvalid;
   logic [DW-1:0] b_rdata;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          rerr;
   arb_state_t    state;

   int checks = 0;
   int errors = 0;
   logic mon_on = 1'b0;

   // Expected response: {owner is B, rerr, data}
   logic [DW+1:0] exp_q[$];

   always #5 clk = ~clk;

   regfile_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .a_req    (a_req),
      .a_addr   (a_addr),
      .a_gnt    (a_gnt),
      .a_stall  (a_stall),
      .a_rvalid (a_rvalid),
      .a_rdata  (a_rdata),
      .b_req    (b_req),
      .b_addr   (b_addr),
      .b_gnt    (b_gnt),
      .b_stall  (b_stall),
      .b_rvalid (b_rvalid),
      .b_rdata  (b_rdata),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rerr     (rerr),
      .state    (state)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle; eg_* are the hand-computed grants, ed/er the grantee's response.
   task automatic drive(input logic ar, input logic [AW-1:0] aa,
                        input logic br, input logic [AW-1:0] ba,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic eg_a, input logic eg_b,
                        input logic [DW-1:0] ed, input logic er, input logic push);
      a_req = ar; a_addr = aa;
      b_req = br; b_addr = ba;
      wr_en = we; wr_addr = wa; wr_data = wd;
      #1;
      chk("a_gnt", 64'(a_gnt), 64'(eg_a));
      chk("b_gnt", 64'(b_gnt), 64'(eg_b));
      chk("a_stall", 64'(a_stall), 64'(ar && !eg_a && !rst));
      chk("b_stall", 64'(b_stall), 64'(br && !eg_b && !rst));
      if (push && (eg_a || eg_b)) exp_q.push_back({eg_b, er, ed});
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: pops an expected response whenever the DUT presents one.
   always @(negedge clk) begin
      if (mon_on) begin
         logic [DW+1:0] e;
         if (a_rvalid && b_rvalid) begin
            chk("both_rvalid", 64'(1), 64'(0));
         end else if (a_rvalid || b_rvalid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rvalid", 64'({a_rvalid, b_rvalid}), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("resp_owner_b", 64'(b_rvalid), 64'(e[DW+1]));
               chk("resp_rerr", 64'(rerr), 64'(e[DW]));
               chk("resp_data", 64'(b_rvalid ? b_rdata : a_rdata), 64'(e[DW-1:0]));
               chk("nonowner_rdata", 64'(b_rvalid ? a_rdata : b_rdata), 64'(0));
            end
         end else begin
            chk("idle_a_rdata", 64'(a_rdata), 64'(0));
            chk("idle_b_rdata", 64'(b_rdata), 64'(0));
            chk("idle_rerr", 64'(rerr), 64'(0));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      @(posedge clk);
      #1;
      mon_on = 1'b1;
      // In reset: requests and a write to reg 7 must be ignored
      drive(1, 1, 1, 2, 1, 7, 32'h77, 0, 0, 0, 0, 0);
      rst = 1'b0;
      chk("rst_state", 64'(state), 64'(LAST_B));
      chk("rst_a_rvalid", 64'(a_rvalid), 64'(0));
      chk("rst_b_rvalid", 64'(b_rvalid), 64'(0));
      chk("rst_rerr", 64'(rerr), 64'(0));

      drive(0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 1);
      drive(1, 3, 0, 0, 1, 1, 32'h1111, 1, 0, 32'hDEADBEEF, 0, 1);
      drive(0, 0, 1, 7, 1, 2, 32'h2222, 0, 1, 32'h0, 0, 1);
      chk("state_after_b", 64'(state), 64'(LAST_B));

      // Contention: strict alternation starting with A
      drive(1, 1, 1, 2, 0, 0, 0, 1, 0, 32'h1111, 0, 1);
      drive(1, 1, 1, 2, 0, 0, 0, 0, 1, 32'h2222, 0, 1);
      drive(1, 1, 1, 2, 0, 0, 0, 1, 0, 32'h1111, 0, 1);
      drive(1, 1, 1, 2, 0, 0, 0, 0, 1, 32'h2222, 0, 1);

      // Read-during-write returns the old value
      drive(0, 0, 0, 0, 1, 5, 32'h22, 0, 0, 0, 0, 1);
      drive(1, 5, 0, 0, 1, 5, 32'h11, 1, 0, 32'h22, 0, 1);
      drive(1, 5, 0, 0, 0, 0, 0, 1, 0, 32'h11, 0, 1);

      // Out-of-range read and write, last valid index
      drive(0, 0, 1, 12, 0, 0, 0, 0, 1, 32'h0, 1, 1);
      drive(0, 0, 1, 9, 1, 12, 32'hFFFFFFFF, 0, 1, 32'h0, 0, 1);
      drive(0, 0, 1, 10, 1, 9, 32'h99, 0, 1, 32'h0, 1, 1);
      drive(1, 9, 1, 12, 0, 0, 0, 1, 0, 32'h99, 0, 1);
      drive(1, 9, 1, 12, 0, 0, 0, 0, 1, 32'h0, 1, 1);
      drive(1, 2, 0, 0, 0, 0, 0, 1, 0, 32'h2222, 0, 1);
      drive(0, 0, 1, 4, 0, 0, 0, 0, 1, 32'h0, 0, 1);

      // Grant then reset: response must be swallowed
      drive(1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      rst = 1'b1;
      drive(1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      chk("rst2_state", 64'(state), 64'(LAST_B));
      drive(1, 3, 1, 1, 0, 0, 0, 1, 0, 32'h0, 0, 1);
      drive(1, 3, 1, 1, 0, 0, 0, 0, 1, 32'h0, 0, 1);
      idle();
      idle();
      chk("exp_q_empty", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter NREGS, default 10, number of architectural registers.
REQ-002 Parameter DW, default 32, register data width.
REQ-003 Parameter AW, default 4, register index width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 a_req  input  1  requester A read request; A holds this until a_gnt.
REQ-007 a_addr  input  AW  requester A register index; held stable while a_req and not a_gnt.
REQ-008 a_gnt  output  1  A owns the read port this cycle (combinational).
REQ-009 a_stall  output  1  a_req and not a_gnt (combinational).
REQ-010 a_rvalid  output  1  A read data valid (registered).
REQ-011 a_rdata  output  DW  A read data (registered).
REQ-012 b_req, b_addr, b_gnt, b_stall, b_rvalid, b_rdata SHALL mirror REQ-006..011 for requester B.
REQ-013 wr_en  input  1  write strobe.
REQ-014 wr_addr  input  AW  write register index.
REQ-015 wr_data  input  DW  write data.
REQ-016 rerr  output  1  registered; pulses with a rvalid when the granted index was >= NREGS.

Function
REQ-017 Block SHALL own an NREGS x DW register array with one shared read port and one dedicated write port.
REQ-018 At most one of a_gnt/b_gnt SHALL be high in any cycle; a grant is issued only to a requester with req high.
REQ-019 Single requester: it SHALL be granted in the same cycle.
REQ-020 Both requesting: arbiter SHALL grant the requester not granted most recently (round-robin).
REQ-021 Arbiter state SHALL be a 2-state FSM, LAST_A / LAST_B; on any grant it SHALL move to the state of the granted requester; with no grant it SHALL hold.
REQ-022 Read latency SHALL be exactly 1 cycle: grant in cycle N -> owner's rvalid=1 and rdata valid in cycle N+1.
REQ-023 Non-owner's rvalid SHALL be 0 and its rdata SHALL be 0 in that cycle; with no grant in N, both rvalid=0 and both rdata=0 in N+1.
REQ-024 Granted index >= NREGS: access SHALL still complete with rvalid=1, rdata=0, rerr=1; otherwise rerr=0.
REQ-025 wr_en with wr_addr < NREGS SHALL update the array at the clock edge; wr_addr >= NREGS SHALL be ignored with no state change.
REQ-026 Read and write to the same index in the same cycle SHALL return the old (pre-write) value; the new value is visible to grants from the next cycle.
REQ-027 A requester holding req continuously SHALL be granted within 2 cycles (no starvation).
REQ-028 Write port SHALL never stall and SHALL be independent of read arbitration.

Reset
REQ-029 rst high at posedge clk SHALL force FSM=LAST_B (A wins the first contention) and clear a_rvalid, b_rvalid, a_rdata, b_rdata, rerr and all array entries to 0.
REQ-030 During rst, a_gnt, b_gnt, a_stall and b_stall SHALL be 0, and wr_en SHALL be ignored.
REQ-031 rst asserted in the cycle after a grant SHALL suppress that grant's rvalid; no response SHALL emerge after reset release.

Structure
REQ-032 NREGS, DW, AW defaults and the FSM state enum (LAST_A, LAST_B) SHALL live in shared package regfile_arb_pkg.
REQ-033 Storage and registered read SHALL be one sub-module, reg_file_bank; arbitration, FSM and response routing SHALL stay in regfile_arbiter.

Verification
REQ-034 After reset, write reg 3 = 0xDEADBEEF, then a_req with a_addr=3 -> a_gnt same cycle; next cycle a_rvalid=1, a_rdata=0xDEADBEEF, b_rvalid=0, rerr=0.
REQ-035 a_req and b_req both held for 4 cycles (addrs 1, 2) -> grants A,B,A,B; stalls are the complement; each rvalid 1 cycle after its grant.
REQ-036 Same cycle: wr_en to reg 5 = 0x11 (old value 0x22) and granted read of reg 5 -> rdata=0x22; a read of reg 5 next cycle -> 0x11.
REQ-037 b_req with b_addr=12 -> next cycle b_rvalid=1, b_rdata=0, rerr=1; wr_addr=12 write -> no register changes.
REQ-038 Grant to A, rst high next cycle -> a_rvalid stays 0; after release, a reread of a previously written register returns 0; both requesting -> A granted first.
